// File: rtl/mac_issue_arbiter.sv
// mac_issue_arbiter
// Shares one pipelined multiply-add unit (PROD = A*B + C, fixed latency LAT,
// no stall) among NREQ requesters. It arbitrates valid/ready requests in
// round-robin or fixed-priority order and registers the winner's operands
// into the unit. A tag pipeline carries the requester ID alongside each
// operation in flight, so every result comes back labelled with the ID of
// the requester that issued it.

module mac_issue_arbiter #(
    parameter int AA   = 6,
    parameter int BB   = 6,
    parameter int CC   = 12,
    parameter int P    = 12,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 2
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                ENABLE,
    input  logic                MODE_FIXED,
    input  logic [NREQ-1:0]     REQ_VALID,
    output logic [NREQ-1:0]     REQ_READY,
    input  logic [NREQ*AA-1:0]  REQ_A,
    input  logic [NREQ*BB-1:0]  REQ_B,
    input  logic [NREQ*CC-1:0]  REQ_C,
    output logic [AA-1:0]       MAC_A,
    output logic [BB-1:0]       MAC_B,
    output logic [CC-1:0]       MAC_C,
    input  logic [P-1:0]        MAC_PROD,
    output logic                RES_VALID,
    output logic [IDW-1:0]      RES_ID,
    output logic [P-1:0]        RES_DATA,
    output logic                BUSY
);

    // Round-robin pointer: the first index searched in the next cycle.
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] scan_base;
    logic [IDW-1:0] next_ptr;
    logic           grant_any;
    logic [IDW-1:0] grant_id;

    // Tag stage k holds the op whose operands reached the unit k cycles ago.
    // Stage LAT lines up with that op's product on MAC_PROD.
    logic [LAT:0]   tag_valid;
    logic [IDW-1:0] tag_id [0:LAT];

    // Index reached by stepping 'offset' places up from 'base', wrapping at
    // NREQ-1. Because base < NREQ and offset < NREQ, one subtraction is
    // enough to bring the sum back into range.
    function automatic logic [IDW-1:0] scan_index(input logic [IDW-1:0] base,
                                                  input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return IDW'(sum);
    endfunction

    // Fixed priority is a round-robin search that always starts at index 0.
    // The pointer itself is left alone, so returning to round-robin later
    // resumes from where it stopped.
    assign scan_base = MODE_FIXED ? '0 : rr_ptr;

    // Grant search: the first valid requester at or after scan_base wins.
    always_comb begin
        // NOTE: every output of this block gets a default before the search
        // loop. Otherwise a path that assigns nothing would infer a latch.
        grant_any = 1'b0;
        grant_id  = '0;
        if (RESETN && ENABLE) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!grant_any && REQ_VALID[scan_index(scan_base, k)]) begin
                    grant_any = 1'b1;
                    grant_id  = scan_index(scan_base, k);
                end
            end
        end
    end

    assign REQ_READY = grant_any ? (NREQ'(1) << grant_id) : '0;
    assign next_ptr  = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
    assign BUSY      = (|tag_valid) | RES_VALID;

    // Issue: register the winner's operands and move the round-robin pointer.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            rr_ptr <= '0;
            MAC_A  <= '0;
            MAC_B  <= '0;
            MAC_C  <= '0;
        end else if (grant_any) begin
            // NOTE: all sequential state uses non-blocking assignment, so
            // every register samples its value from before the clock edge.
            MAC_A <= REQ_A[int'(grant_id)*AA +: AA];
            MAC_B <= REQ_B[int'(grant_id)*BB +: BB];
            MAC_C <= REQ_C[int'(grant_id)*CC +: CC];
            if (!MODE_FIXED) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    // Tag pipeline: shifts every cycle, in step with the unit's own pipeline.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            tag_valid <= '0;
            // NOTE: the tag IDs are cleared as well as the valids. The
            // storage is tiny, and clearing it keeps RES_ID at a known 0
            // while the block is idle after reset.
            for (int i = 0; i <= LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_valid <= {tag_valid[LAT-1:0], grant_any};
            tag_id[0] <= grant_id;
            for (int i = 1; i <= LAT; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Result stage: capture the product whenever its tag is valid.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            RES_VALID <= 1'b0;
            RES_ID    <= '0;
            RES_DATA  <= '0;
        end else begin
            RES_VALID <= tag_valid[LAT];
            RES_ID    <= tag_id[LAT];
            if (tag_valid[LAT]) begin
                RES_DATA <= MAC_PROD;
            end
        end
    end

endmodule

// File: tb/tb_mac_issue_arbiter.sv
// tb_mac_issue_arbiter
// Directed, table-driven bench for mac_issue_arbiter at its default
// parameters. It includes a behavioural model of the external
// multiply-add unit (latency 2, no reset).

module tb_mac_issue_arbiter;

    localparam int AA = 6, BB = 6, CC = 12, P = 12, NREQ = 4, IDW = 2, LAT = 2;

    logic              CLK = 1'b0;
    logic              RESETN;
    logic              ENABLE;
    logic              MODE_FIXED;
    logic [NREQ-1:0]   REQ_VALID;
    logic [NREQ-1:0]   REQ_READY;
    logic [NREQ*AA-1:0] REQ_A;
    logic [NREQ*BB-1:0] REQ_B;
    logic [NREQ*CC-1:0] REQ_C;
    logic [AA-1:0]     MAC_A;
    logic [BB-1:0]     MAC_B;
    logic [CC-1:0]     MAC_C;
    logic [P-1:0]      MAC_PROD;
    logic              RES_VALID;
    logic [IDW-1:0]    RES_ID;
    logic [P-1:0]      RES_DATA;
    logic              BUSY;

    always #5 CLK = ~CLK;

    mac_issue_arbiter #(
        .AA(AA), .BB(BB), .CC(CC), .P(P), .NREQ(NREQ), .IDW(IDW), .LAT(LAT)
    ) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .ENABLE     (ENABLE),
        .MODE_FIXED (MODE_FIXED),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_A      (REQ_A),
        .REQ_B      (REQ_B),
        .REQ_C      (REQ_C),
        .MAC_A      (MAC_A),
        .MAC_B      (MAC_B),
        .MAC_C      (MAC_C),
        .MAC_PROD   (MAC_PROD),
        .RES_VALID  (RES_VALID),
        .RES_ID     (RES_ID),
        .RES_DATA   (RES_DATA),
        .BUSY       (BUSY)
    );

    // External multiply-add unit: operands in cycle k produce PROD in cycle k+2.
    logic [P-1:0] mac_p1, mac_p2;
    always @(posedge CLK) begin
        mac_p1 <= ({6'd0, MAC_A} * {6'd0, MAC_B}) + MAC_C;
        mac_p2 <= mac_p1;
    end
    assign MAC_PROD = mac_p2;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        mode;
        logic [3:0]  valid;
        logic [3:0]  exp_ready;
        logic        exp_rv;
        logic [1:0]  exp_id;
        logic [11:0] exp_data;
        logic        exp_busy;
    } vec_t;

    vec_t q[$];

    function automatic vec_t mk(input logic rst_n, input logic en, input logic mode,
                                input logic [3:0] valid, input logic [3:0] ready,
                                input logic rv, input logic [1:0] id,
                                input logic [11:0] data, input logic busy);
        vec_t v;
        v.rst_n = rst_n; v.en = en; v.mode = mode; v.valid = valid;
        v.exp_ready = ready; v.exp_rv = rv; v.exp_id = id;
        v.exp_data = data; v.exp_busy = busy;
        return v;
    endfunction

    // Applies the queued vectors one cycle each. The caller starts just after
    // a rising edge. Outputs are sampled on the falling edge of the same cycle.
    task automatic run_seq(input string name);
        foreach (q[i]) begin
            RESETN     = q[i].rst_n;
            ENABLE     = q[i].en;
            MODE_FIXED = q[i].mode;
            REQ_VALID  = q[i].valid;
            @(negedge CLK);
            check($sformatf("%s[%0d].ready", name, i), 32'(REQ_READY), 32'(q[i].exp_ready));
            check($sformatf("%s[%0d].res_valid", name, i), 32'(RES_VALID), 32'(q[i].exp_rv));
            if (q[i].exp_rv) begin
                check($sformatf("%s[%0d].res_id", name, i), 32'(RES_ID), 32'(q[i].exp_id));
            end
            check($sformatf("%s[%0d].res_data", name, i), 32'(RES_DATA), 32'(q[i].exp_data));
            check($sformatf("%s[%0d].busy", name, i), 32'(BUSY), 32'(q[i].exp_busy));
            @(posedge CLK);
            #1;
        end
        q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Fixed operands per requester; the expected results are:
        // r0: 63*63+4095 = 8064 mod 4096 = 3968
        // r1: 3*5+7 = 22, r2: 4*5+6 = 26, r3: 10*20+30 = 230
        REQ_A      = {6'd10, 6'd4, 6'd3, 6'd63};
        REQ_B      = {6'd20, 6'd5, 6'd5, 6'd63};
        REQ_C      = {12'd30, 12'd6, 12'd7, 12'd4095};
        RESETN     = 1'b0;
        ENABLE     = 1'b1;
        MODE_FIXED = 1'b0;
        REQ_VALID  = 4'b1111;

        @(negedge CLK);
        check("reset.ready_held_low", 32'(REQ_READY), 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("reset.res_valid", 32'(RES_VALID), 32'd0);
        check("reset.res_id", 32'(RES_ID), 32'd0);
        check("reset.res_data", 32'(RES_DATA), 32'd0);
        check("reset.mac_a", 32'(MAC_A), 32'd0);
        check("reset.mac_b", 32'(MAC_B), 32'd0);
        check("reset.mac_c", 32'(MAC_C), 32'd0);
        check("reset.busy", 32'(BUSY), 32'd0);
        check("reset.ready", 32'(REQ_READY), 32'd0);
        @(posedge CLK);
        #1;

        // Main table: round-robin fairness, then a single op, then wrap arithmetic.
        //              rst en md valid  ready  rv id data     busy
        q.push_back(mk(1, 1, 0, 4'hF, 4'b0001, 0, 0, 12'd0,    0));
        q.push_back(mk(1, 1, 0, 4'hF, 4'b0010, 0, 0, 12'd0,    1));
        q.push_back(mk(1, 1, 0, 4'hF, 4'b0100, 0, 0, 12'd0,    1));
        q.push_back(mk(1, 1, 0, 4'hF, 4'b1000, 0, 0, 12'd0,    1));
        q.push_back(mk(1, 1, 0, 4'hF, 4'b0001, 1, 0, 12'd3968, 1));
        q.push_back(mk(1, 1, 0, 4'hF, 4'b0010, 1, 1, 12'd22,   1));
        q.push_back(mk(1, 1, 0, 4'hF, 4'b0100, 1, 2, 12'd26,   1));
        q.push_back(mk(1, 1, 0, 4'hF, 4'b1000, 1, 3, 12'd230,  1));
        q.push_back(mk(1, 1, 0, 4'h0, 4'b0000, 1, 0, 12'd3968, 1));
        q.push_back(mk(1, 1, 0, 4'h0, 4'b0000, 1, 1, 12'd22,   1));
        q.push_back(mk(1, 1, 0, 4'h0, 4'b0000, 1, 2, 12'd26,   1));
        q.push_back(mk(1, 1, 0, 4'h0, 4'b0000, 1, 3, 12'd230,  1));
        q.push_back(mk(1, 1, 0, 4'h2, 4'b0010, 0, 0, 12'd230,  0));
        for (int i = 0; i < 3; i++)
            q.push_back(mk(1, 1, 0, 4'h0, 4'b0000, 0, 0, 12'd230, 1));
        q.push_back(mk(1, 1, 0, 4'h0, 4'b0000, 1, 1, 12'd22,   1));
        q.push_back(mk(1, 1, 0, 4'h1, 4'b0001, 0, 0, 12'd22,   0));
        for (int i = 0; i < 3; i++)
            q.push_back(mk(1, 1, 0, 4'h0, 4'b0000, 0, 0, 12'd22, 1));
        q.push_back(mk(1, 1, 0, 4'h0, 4'b0000, 1, 0, 12'd3968, 1));
        q.push_back(mk(1, 1, 0, 4'h0, 4'b0000, 0, 0, 12'd3968, 0));
        run_seq("table");

        // With no grants since the last issue, the operand registers still
        // hold requester 0's operands.
        check("hold.mac_a", 32'(MAC_A), 32'd63);
        check("hold.mac_b", 32'(MAC_B), 32'd63);
        check("hold.mac_c", 32'(MAC_C), 32'd4095);

        // Fixed priority. The pointer is 1 here. Granting requester 3 moves it
        // to 0. Fixed mode must leave it at 0; round-robin then grants 2, then 3.
        q.push_back(mk(1, 1, 0, 4'b1000, 4'b1000, 0, 0, 12'd3968, 0));
        q.push_back(mk(1, 1, 1, 4'b1100, 4'b0100, 0, 0, 12'd3968, 1));
        q.push_back(mk(1, 1, 1, 4'b1100, 4'b0100, 0, 0, 12'd3968, 1));
        q.push_back(mk(1, 1, 1, 4'b1100, 4'b0100, 0, 0, 12'd3968, 1));
        q.push_back(mk(1, 1, 0, 4'b1100, 4'b0100, 1, 3, 12'd230,  1));
        q.push_back(mk(1, 1, 0, 4'b1100, 4'b1000, 1, 2, 12'd26,   1));
        q.push_back(mk(1, 1, 0, 4'b0000, 4'b0000, 1, 2, 12'd26,   1));
        q.push_back(mk(1, 1, 0, 4'b0000, 4'b0000, 1, 2, 12'd26,   1));
        q.push_back(mk(1, 1, 0, 4'b0000, 4'b0000, 1, 2, 12'd26,   1));
        q.push_back(mk(1, 1, 0, 4'b0000, 4'b0000, 1, 3, 12'd230,  1));
        q.push_back(mk(1, 1, 0, 4'b0000, 4'b0000, 0, 0, 12'd230,  0));
        run_seq("fixed");

        // ENABLE drop with requests still pending. The pointer is 0 here.
        q.push_back(mk(1, 1, 0, 4'b0011, 4'b0001, 0, 0, 12'd230,  0));
        q.push_back(mk(1, 1, 0, 4'b0011, 4'b0010, 0, 0, 12'd230,  1));
        q.push_back(mk(1, 0, 0, 4'b0011, 4'b0000, 0, 0, 12'd230,  1));
        q.push_back(mk(1, 0, 0, 4'b0011, 4'b0000, 0, 0, 12'd230,  1));
        q.push_back(mk(1, 0, 0, 4'b0011, 4'b0000, 1, 0, 12'd3968, 1));
        q.push_back(mk(1, 0, 0, 4'b0011, 4'b0000, 1, 1, 12'd22,   1));
        q.push_back(mk(1, 0, 0, 4'b0011, 4'b0000, 0, 0, 12'd22,   0));
        q.push_back(mk(1, 0, 0, 4'b0011, 4'b0000, 0, 0, 12'd22,   0));
        run_seq("enable");

        // Reset mid-flight. The pointer is 2 here. Requester 2 issues in
        // cycle 0, and reset is asserted in cycle 2 with a request pending.
        q.push_back(mk(1, 1, 0, 4'b0100, 4'b0100, 0, 0, 12'd22, 0));
        q.push_back(mk(1, 1, 0, 4'b0000, 4'b0000, 0, 0, 12'd22, 1));
        q.push_back(mk(0, 1, 0, 4'b0100, 4'b0000, 0, 0, 12'd22, 1));
        q.push_back(mk(1, 1, 0, 4'b0000, 4'b0000, 0, 0, 12'd0,  0));
        run_seq("rst_a");
        check("rst.mac_a", 32'(MAC_A), 32'd0);
        check("rst.mac_b", 32'(MAC_B), 32'd0);
        check("rst.mac_c", 32'(MAC_C), 32'd0);
        check("rst.res_id", 32'(RES_ID), 32'd0);
        for (int i = 0; i < 5; i++)
            q.push_back(mk(1, 1, 0, 4'b0000, 4'b0000, 0, 0, 12'd0, 0));
        run_seq("rst_b");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_issue_arbiter.md
Name: mac_issue_arbiter

Overview:
- Shares one pipelined multiply-add unit (PROD = A*B + C, latency LAT, no reset, no stall) among NREQ requesters.
- Arbitrates valid/ready requests, drives registered operands into the unit and tracks a requester tag alongside each in-flight operation.
- Returns each registered result with the issuing requester's ID.
- Sits between the requesting datapath blocks and the multiply-add instance.

Parameters:
- AA, 6, width of operand A
- BB, 6, width of operand B
- CC, 12, width of addend C
- P, 12, width of product/result
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width, ceil(log2(NREQ))
- LAT, 2, multiply-add latency: operands on MAC_A/B/C in cycle k produce MAC_PROD in cycle k+LAT (LAT >= 1)

Ports:
- CLK  in  1  clock, all state on rising edge
- RESETN  in  1  synchronous active-low reset
- ENABLE  in  1  1 = grants allowed; 0 = no new grants, in-flight ops complete
- MODE_FIXED  in  1  1 = fixed priority (lowest index wins); 0 = round-robin
- REQ_VALID  in  NREQ  per-requester request valid
- REQ_READY  out  NREQ  per-requester grant, one-hot or zero, combinational
- REQ_A  in  NREQ*AA  packed A operands, requester i at [i*AA +: AA]
- REQ_B  in  NREQ*BB  packed B operands
- REQ_C  in  NREQ*CC  packed C operands
- MAC_A  out  AA  registered operand A to the unit
- MAC_B  out  BB  registered operand B to the unit
- MAC_C  out  CC  registered operand C to the unit
- MAC_PROD  in  P  product from the unit
- RES_VALID  out  1  result valid, single-cycle pulse, no backpressure
- RES_ID  out  IDW  requester index of the result
- RES_DATA  out  P  result value
- BUSY  out  1  1 while any tag in the pipeline is valid or RES_VALID=1

Behaviour:
- Reset (RESETN=0 at an edge) clears: round-robin pointer=0; all tag valids=0; RES_VALID=0; RES_ID=0; RES_DATA=0; MAC_A/B/C=0. REQ_READY=0 while RESETN=0.
- Grant, combinational:
  - Candidates are REQ_VALID bits, only when ENABLE=1 and RESETN=1.
  - Round-robin: search from the pointer upward, wrapping at NREQ-1 -> 0; first valid wins.
  - Fixed priority: lowest valid index wins.
  - REQ_READY never depends on REQ_READY; requesters may hold REQ_VALID until granted.
- Issue: a handshake in cycle t happens when REQ_VALID[i] & REQ_READY[i]. At the end of t:
  - MAC_A/B/C load requester i's operands.
  - Tag stage 0 loads {1, i}.
  - Round-robin mode only: pointer <= (i+1) mod NREQ.
  - Fixed mode: pointer unchanged.
- No grant in a cycle: MAC_A/B/C hold their values; tag stage 0 loads valid=0; pointer holds.
- Tag pipeline: LAT+1 stages, shifted every cycle. The op issued in cycle t presents operands in cycle t+1 and MAC_PROD in cycle t+1+LAT.
- Result stage, at the end of cycle t+1+LAT:
  - RES_VALID <= tag valid; RES_ID <= tag id.
  - RES_DATA <= MAC_PROD only when the tag is valid; otherwise RES_DATA holds.
- Latency: handshake in cycle t -> RES_VALID=1 in cycle t+LAT+2 (t+4 at default).
- Throughput: one issue per cycle. Back-to-back results come out in issue order.
- Arithmetic is done by the unit: A*B+C truncated modulo 2^P, unsigned. The arbiter does not modify data.
- ENABLE deasserted mid-stream: no new grants from that cycle; in-flight results still appear; BUSY falls in the cycle after the last RES_VALID.
- MODE_FIXED change: takes effect in the same cycle. The pointer value is retained for a later return to round-robin.
- A requester dropping REQ_VALID before grant is legal; nothing is issued for it.
- Reset mid-operation: all tag valids clear, so in-flight results are discarded. No RES_VALID until a new issue completes, even though the unit's own pipeline is not reset.
- NREQ not a power of two: the pointer wraps from NREQ-1 to 0 and never takes an unused index.

Test Plan:
- Single op, round-robin: requester 1 presents A=3, B=5, C=7 in cycle 0. Required: REQ_READY=0010 in cycle 0; RES_VALID=1, RES_ID=1, RES_DATA=22 in cycle 4 only.
- Wrap arithmetic: A=63, B=63, C=4095 from requester 0. Required: RES_DATA=3968 (8064 mod 4096).
- Round-robin fairness: all four REQ_VALID held high for 8 cycles with distinct operands. Required: grant order 0,1,2,3,0,1,2,3; results in cycles 4..11 with RES_ID in the same order and correct values.
- Fixed priority: MODE_FIXED=1, requesters 2 and 3 both valid for 3 cycles. Required: requester 2 granted every cycle, requester 3 never. Then set MODE_FIXED=0 with the pointer at 0 and requesters 2 and 3 still valid: requester 2 is granted, then 3.
- ENABLE and BUSY: issue in cycles 0 and 1, ENABLE=0 from cycle 2 with requests pending. Required: REQ_READY=0 from cycle 2; results in cycles 4 and 5; BUSY=0 from cycle 6.
- Reset mid-flight: issue in cycle 0, RESETN=0 in cycle 2, RESETN=1 from cycle 3 with no requests. Required: RES_VALID stays 0 through cycle 8; BUSY=0 from cycle 3; MAC_A/B/C=0.
